shifter: RTL and testbench

SHIFTER -- requirements
Module: shifter

---
 rtl/shifter.sv | 93 +++++++++
 tb/tb_shifter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/shifter.sv
// 32-bit registered barrel shifter: pass-through, logical left, arithmetic right
// and logical right, selected by {ctl1,ctl0}, with one cycle of latency.
module shifter (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] out,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        ctl0,
    input  logic        ctl1
);

    typedef enum logic [1:0] {
        OP_PASS = 2'b00,
        OP_SLL  = 2'b01,
        OP_SRA  = 2'b10,
        OP_SRL  = 2'b11
    } op_e;

    op_e         op_s;
    logic        left_s;
    logic        fill_s;
    logic        pass_s;
    logic [4:0]  amt_s;
    logic [31:0] result_s;
    logic [31:0] stage_s [0:5];
    logic        unused_b_s;

    assign op_s  = op_e'({ctl1, ctl0});
    assign amt_s = B[4:0];

    // Upper shift-amount bits have no effect on the result.
    assign unused_b_s = ^B[31:5];

    // Decode the operation into shift direction, fill bit and bypass.
    always_comb begin
        left_s = 1'b0;
        fill_s = 1'b0;
        pass_s = 1'b0;
        case (op_s)
            OP_PASS: begin
                left_s = 1'b0;
                fill_s = 1'b0;
                pass_s = 1'b1;
            end
            OP_SLL: begin
                left_s = 1'b1;
                fill_s = 1'b0;
                pass_s = 1'b0;
            end
            OP_SRA: begin
                left_s = 1'b0;
                fill_s = A[31];
                pass_s = 1'b0;
            end
            OP_SRL: begin
                left_s = 1'b0;
                fill_s = 1'b0;
                pass_s = 1'b0;
            end
            default: begin
                left_s = 1'b0;
                fill_s = 1'b0;
                pass_s = 1'b1;
            end
        endcase
    end

    assign stage_s[0] = A;

    // Logarithmic stages of 1, 2, 4, 8 and 16 positions, each gated by one amount bit.
    for (genvar i = 0; i < 5; i++) begin : g_stage
        localparam int K = 1 << i;
        logic [31:0] shl_s;
        logic [31:0] shr_s;

        assign shl_s = {stage_s[i][31-K:0], {K{1'b0}}};
        assign shr_s = {{K{fill_s}}, stage_s[i][31:K]};
        assign stage_s[i+1] = amt_s[i] ? (left_s ? shl_s : shr_s) : stage_s[i];
    end

    assign result_s = pass_s ? A : stage_s[5];

    // Output register; reset clears it immediately and drops any pending result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= 32'h0000_0000;
        end else begin
            out <= result_s;
        end
    end

endmodule

// File: tb/tb_shifter.sv
// Self-checking bench for shifter: expected results are queued when stimulus is
// driven and compared one cycle later when the registered output appears.
module tb_shifter;

    logic        clk;
    logic        rst_n;
    logic [31:0] out;
    logic [31:0] A;
    logic [31:0] B;
    logic        ctl0;
    logic        ctl1;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q [$];

    shifter dut (
        .clk  (clk),
        .rst_n(rst_n),
        .out  (out),
        .A    (A),
        .B    (B),
        .ctl0 (ctl0),
        .ctl1 (ctl1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [31:0] exp;
        string       tag;
    } vec_t;

    vec_t vecs [$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
        int n;
        n = int'(b[4:0]);
        case (op)
            2'b01:   return a << n;
            2'b10:   return 32'($signed(a) >>> n);
            2'b11:   return a >> n;
            default: return a;
        endcase
    endfunction

    // Drive one operation at the falling edge and check it after the next rising edge.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                          input string tag);
        logic [31:0] e;
        @(negedge clk);
        A = a;
        B = b;
        {ctl1, ctl0} = op;
        exp_q.push_back(model(a, b, op));
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_noexp"}, out, 32'hDEAD_BEEF);
        end else begin
            e = exp_q.pop_front();
            check_eq(tag, out, e);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back('{32'h0000_0001, 32'd31, 2'b01, 32'h8000_0000, "sll31"});
        vecs.push_back('{32'h0000_0001, 32'd7,  2'b01, 32'h0000_0080, "sll7"});
        vecs.push_back('{32'h8000_0000, 32'd31, 2'b10, 32'hFFFF_FFFF, "sra31"});
        vecs.push_back('{32'h8000_0000, 32'd7,  2'b10, 32'hFF00_0000, "sra7"});
        vecs.push_back('{32'h8000_0000, 32'd1,  2'b10, 32'hC000_0000, "sra1"});
        vecs.push_back('{32'h8000_0000, 32'd31, 2'b11, 32'h0000_0001, "srl31"});
        vecs.push_back('{32'h8000_0000, 32'd7,  2'b11, 32'h0100_0000, "srl7"});
        vecs.push_back('{32'hFEFF_FFFF, 32'd0,  2'b00, 32'hFEFF_FFFF, "pass_b0"});
        vecs.push_back('{32'hFEFF_FFFF, 32'd0,  2'b01, 32'hFEFF_FFFF, "sll_b0"});
        vecs.push_back('{32'hFEFF_FFFF, 32'd0,  2'b10, 32'hFEFF_FFFF, "sra_b0"});
        vecs.push_back('{32'hFEFF_FFFF, 32'd0,  2'b11, 32'hFEFF_FFFF, "srl_b0"});
        vecs.push_back('{32'hFEFF_FFFF, 32'd7,  2'b11, 32'h01FD_FFFF, "srl7_fe"});
        vecs.push_back('{32'hFEFF_FFFF, 32'd7,  2'b01, 32'h7FFF_FF80, "sll7_fe"});
        vecs.push_back('{32'h7FFF_FFFF, 32'd7,  2'b10, 32'h00FF_FFFF, "sra7_pos"});
        vecs.push_back('{32'h7FFF_FFFF, 32'h21, 2'b01, 32'hFFFF_FFFE, "sll_b33"});
        vecs.push_back('{32'h1234_5678, 32'd32, 2'b11, 32'h1234_5678, "srl_b32"});
        vecs.push_back('{32'hA5A5_0F0F, 32'hFFFF_FFFF, 2'b00, 32'hA5A5_0F0F, "pass_bff"});
        vecs.push_back('{32'hF000_000F, 32'd4,  2'b10, 32'hFF00_0000, "sra4"});
        vecs.push_back('{32'hF000_000F, 32'd4,  2'b01, 32'h0000_00F0, "sll4"});
        vecs.push_back('{32'hF000_000F, 32'd16, 2'b11, 32'h0000_F000, "srl16"});

        rst_n = 1'b0;
        A = 32'hFFFF_FFFF;
        B = 32'd0;
        {ctl1, ctl0} = 2'b00;

        // Held in reset through clock edges with nonzero inputs.
        #2;
        check_eq("reset_init", out, 32'h0000_0000);
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_held", out, 32'h0000_0000);

        @(negedge clk);
        rst_n = 1'b1;

        // Fixed table: the bench's hand-derived value must agree with the model too.
        foreach (vecs[i]) begin
            check_eq({"model_", vecs[i].tag}, model(vecs[i].a, vecs[i].b, vecs[i].op), vecs[i].exp);
            run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].tag);
        end

        // Input changes between edges must not reach the output.
        run_op(32'h0000_00FF, 32'd8, 2'b01, "hold_pre");
        A = 32'h0;
        {ctl1, ctl0} = 2'b11;
        #3;
        check_eq("hold_between", out, 32'h0000_FF00);

        // Asynchronous reset mid-run with a nonzero output.
        run_op(32'hDEAD_BEEF, 32'd0, 2'b00, "pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst", out, 32'h0000_0000);
        exp_q.delete();
        @(posedge clk);
        #1;
        check_eq("rst_discard", out, 32'h0000_0000);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'h0000_0003, 32'd2, 2'b01, "post_rst");
        run_op(32'hCAFE_F00D, 32'd5, 2'b00, "post_rst_pass");

        // Random operations.
        for (int i = 0; i < 60; i++) begin
            run_op($urandom, $urandom, 2'($urandom_range(0, 3)), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
